// File: rtl/instruction_cache_refill_engine_pkg.sv
// Shared definitions for the instruction-cache refill engine: FSM encoding,
// logic-level constants and the parameter derivations used by every file.
package instruction_cache_refill_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } refill_state_e;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Smallest n with 2**n >= value; evaluated at elaboration time only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of L2 response beats that make up one L1 line.
    function automatic int calc_beats(input int block_width, input int bus_width);
        return block_width / bus_width;
    endfunction

    // Width of a block address once the byte offset within a line is dropped.
    function automatic int calc_block_addr_width(input int address_width,
                                                 input int word_size,
                                                 input int word_per_block);
        return address_width - clog2(word_size * word_per_block);
    endfunction

    // Beat counter width; a single-beat line still needs a one-bit counter.
    function automatic int calc_counter_width(input int beats);
        return (beats > 1) ? clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/instruction_cache_refill_engine_beat_assembler.sv
// Collects narrow L2 response beats into one full cache line, lowest slice
// first, and flags a LAST marker that disagrees with the beat count.
module refill_beat_assembler
    import instruction_cache_refill_engine_pkg::*;
#(
    parameter int   BLOCK_WIDTH = 512,
    parameter int   BUS_WIDTH   = 128,
    localparam int  BEATS       = calc_beats(BLOCK_WIDTH, BUS_WIDTH),
    localparam int  COUNT_WIDTH = calc_counter_width(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   beat_accept,
    input  logic [BUS_WIDTH-1:0]   beat_data,
    input  logic                   beat_last,
    output logic [BLOCK_WIDTH-1:0] line,
    output logic                   done,
    output logic                   error
);

    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(BEATS - 1);

    logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [BLOCK_WIDTH-1:0] line_q, line_d;
    logic                   error_q, error_d;
    logic                   final_beat;

    // Next-state: write the accepted beat into its slice, advance or wrap the
    // counter, and latch an error whenever LAST does not match the final beat.
    always_comb begin
        beat_count_d = beat_count_q;
        line_d       = line_q;
        error_d      = error_q;
        done         = LOW;
        final_beat   = (beat_count_q == LAST_INDEX);
        if (clear) begin
            beat_count_d = '0;
        end else if (beat_accept) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_count_q == COUNT_WIDTH'(k)) begin
                    line_d[k*BUS_WIDTH +: BUS_WIDTH] = beat_data;
                end
            end
            if (beat_last != final_beat) begin
                error_d = HIGH;
            end
            if (final_beat) begin
                beat_count_d = '0;
                done         = HIGH;
            end else begin
                beat_count_d = beat_count_q + 1'b1;
            end
        end
    end

    // State registers; the line is cleared only by reset and otherwise keeps
    // the previous block until each slice is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
            line_q       <= '0;
            error_q      <= LOW;
        end else begin
            beat_count_q <= beat_count_d;
            line_q       <= line_d;
            error_q      <= error_d;
        end
    end

    assign line  = line_q;
    assign error = error_q;

endmodule

// File: rtl/instruction_cache_refill_engine.sv
// Refill engine between the L1 instruction-cache controller and L2: takes one
// block miss, issues it to L2, assembles the returned beats and hands the line
// back to L1. Only one miss is in flight at any time.
module instruction_cache_refill_engine
    import instruction_cache_refill_engine_pkg::*;
#(
    parameter int   ADDRESS_WIDTH    = 32,
    parameter int   BLOCK_WIDTH      = 512,
    parameter int   BUS_WIDTH        = 128,
    parameter int   WORD_SIZE        = 4,
    parameter int   WORD_PER_BLOCK   = 16,
    localparam int  BLOCK_ADDR_WIDTH = calc_block_addr_width(ADDRESS_WIDTH, WORD_SIZE, WORD_PER_BLOCK)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
    output logic                        ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
    input  logic [BLOCK_ADDR_WIDTH-1:0] ADDRESS_TO_L2_INSTRUCTION_CACHE,
    output logic                        DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
    input  logic                        DATA_FROM_L2_READY_INSTRUCTION_CACHE,
    output logic [BLOCK_WIDTH-1:0]      DATA_FROM_L2_INSTRUCTION_CACHE,
    output logic                        L2_REQ_VALID,
    input  logic                        L2_REQ_READY,
    output logic [BLOCK_ADDR_WIDTH-1:0] L2_REQ_ADDRESS,
    input  logic                        L2_RSP_VALID,
    output logic                        L2_RSP_READY,
    input  logic [BUS_WIDTH-1:0]        L2_RSP_DATA,
    input  logic                        L2_RSP_LAST,
    output logic                        PROTOCOL_ERROR,
    output logic [31:0]                 REFILL_COUNT
);

    refill_state_e               state_q, state_d;
    logic [BLOCK_ADDR_WIDTH-1:0] address_q, address_d;
    logic [31:0]                 refill_count_q, refill_count_d;

    logic request_fire;
    logic l2_request_fire;
    logic beat_fire;
    logic line_fire;
    logic fill_done;

    // Handshake strobes; every port's valid/ready is a pure decode of the
    // registered state, so none of them depends combinationally on an input
    // other than reset.
    assign ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = (state_q == IDLE) & ~RST;
    assign L2_REQ_VALID                          = (state_q == REQ);
    assign L2_RSP_READY                          = (state_q == FILL);
    assign DATA_FROM_L2_VALID_INSTRUCTION_CACHE  = (state_q == RESP);

    assign request_fire    = ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE & ADDRESS_TO_L2_READY_INSTRUCTION_CACHE;
    assign l2_request_fire = L2_REQ_VALID & L2_REQ_READY;
    assign beat_fire       = L2_RSP_VALID & L2_RSP_READY;
    assign line_fire       = DATA_FROM_L2_VALID_INSTRUCTION_CACHE & DATA_FROM_L2_READY_INSTRUCTION_CACHE;

    refill_beat_assembler #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .BUS_WIDTH   (BUS_WIDTH)
    ) u_beat_assembler (
        .clk         (CLK),
        .rst         (RST),
        .clear       (l2_request_fire),
        .beat_accept (beat_fire),
        .beat_data   (L2_RSP_DATA),
        .beat_last   (L2_RSP_LAST),
        .line        (DATA_FROM_L2_INSTRUCTION_CACHE),
        .done        (fill_done),
        .error       (PROTOCOL_ERROR)
    );

    // FSM next-state: latch the miss address, wait for L2 to take it, wait
    // for the assembler to count in a full line, then hold it until L1 takes
    // it. A request arriving alongside the RESP handshake waits for IDLE.
    always_comb begin
        state_d        = state_q;
        address_d      = address_q;
        refill_count_d = refill_count_q;
        case (state_q)
            IDLE: begin
                if (request_fire) begin
                    address_d = ADDRESS_TO_L2_INSTRUCTION_CACHE;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (l2_request_fire) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (line_fire) begin
                    state_d = IDLE;
                    if (refill_count_q != 32'hFFFF_FFFF) begin
                        refill_count_d = refill_count_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and bookkeeping registers; reset abandons any refill in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            address_q      <= '0;
            refill_count_q <= '0;
        end else begin
            state_q        <= state_d;
            address_q      <= address_d;
            refill_count_q <= refill_count_d;
        end
    end

    assign L2_REQ_ADDRESS = address_q;
    assign REFILL_COUNT   = refill_count_q;

endmodule

// File: tb/tb_instruction_cache_refill_engine.sv
// Directed bench for the instruction-cache refill engine: a requester, an L2
// responder and a line receiver run as parallel threads per refill.
module tb_instruction_cache_refill_engine;

    localparam int ADDR_W  = 26;
    localparam int LINE_W  = 512;
    localparam int BEAT_W  = 128;
    localparam int TIMEOUT = 60;

    logic              CLK = 1'b0;
    logic              RST;
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_in;
    logic              data_valid;
    logic              data_ready;
    logic [LINE_W-1:0] data_out;
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_address;
    logic              l2_rsp_valid;
    logic              l2_rsp_ready;
    logic [BEAT_W-1:0] l2_rsp_data;
    logic              l2_rsp_last;
    logic              protocol_error;
    logic [31:0]       refill_count;

    int check_count    = 0;
    int error_count    = 0;
    int cycle_count    = 0;
    int beats_accepted = 0;
    int accept_cycle   = 0;
    int beats_before;

    instruction_cache_refill_engine dut (
        .CLK                                   (CLK),
        .RST                                   (RST),
        .ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE (addr_valid),
        .ADDRESS_TO_L2_READY_INSTRUCTION_CACHE (addr_ready),
        .ADDRESS_TO_L2_INSTRUCTION_CACHE       (addr_in),
        .DATA_FROM_L2_VALID_INSTRUCTION_CACHE  (data_valid),
        .DATA_FROM_L2_READY_INSTRUCTION_CACHE  (data_ready),
        .DATA_FROM_L2_INSTRUCTION_CACHE        (data_out),
        .L2_REQ_VALID                          (l2_req_valid),
        .L2_REQ_READY                          (l2_req_ready),
        .L2_REQ_ADDRESS                        (l2_req_address),
        .L2_RSP_VALID                          (l2_rsp_valid),
        .L2_RSP_READY                          (l2_rsp_ready),
        .L2_RSP_DATA                           (l2_rsp_data),
        .L2_RSP_LAST                           (l2_rsp_last),
        .PROTOCOL_ERROR                        (protocol_error),
        .REFILL_COUNT                          (refill_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Cycle index and count of beats actually handed over on the L2 port.
    always @(posedge CLK) begin
        cycle_count <= cycle_count + 1;
        if (l2_rsp_valid && l2_rsp_ready) begin
            beats_accepted <= beats_accepted + 1;
        end
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Beat k of a test pattern: the 4-bit value seed+k repeated across the beat.
    function automatic logic [BEAT_W-1:0] beatData(input int seed, input int k);
        logic [3:0] nibble;
        nibble = 4'(seed + k);
        return {32{nibble}};
    endfunction

    // Full line the engine should assemble from beats 0..3 of a pattern.
    function automatic logic [LINE_W-1:0] lineData(input int seed);
        return {beatData(seed, 3), beatData(seed, 2), beatData(seed, 1), beatData(seed, 0)};
    endfunction

    // L1 side: present a miss until accepted, then check the latched address.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr);
        int waited = 0;
        addr_valid = 1'b1;
        addr_in    = addr;
        while (!addr_ready && waited < TIMEOUT) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (!addr_ready) begin
            checkOutput("request_accept_timeout", 0, 1);
            addr_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        accept_cycle = cycle_count;
        addr_valid   = 1'b0;
        checkOutput("l2_req_address_latched", l2_req_address, addr);
        checkOutput("l2_req_valid_next_cycle", l2_req_valid, 1);
    endtask

    // L2 side: optionally stall the request, then return n_beats beats with
    // gap idle cycles between them and LAST on beat last_index.
    task automatic serveL2(input int req_stall, input int gap, input int last_index,
                           input int n_beats, input int seed, input logic [ADDR_W-1:0] addr);
        int waited = 0;
        l2_req_ready = (req_stall == 0);
        while (!l2_req_valid && waited < TIMEOUT) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (!l2_req_valid) begin
            checkOutput("l2_request_timeout", 0, 1);
            return;
        end
        for (int s = 0; s < req_stall; s++) begin
            @(posedge CLK); #1;
            checkOutput("req_address_stable", l2_req_address, addr);
            checkOutput("req_valid_held", l2_req_valid, 1);
        end
        l2_req_ready = 1'b1;
        @(posedge CLK); #1;
        l2_req_ready = 1'b0;
        for (int k = 0; k < n_beats; k++) begin
            l2_rsp_valid = 1'b1;
            l2_rsp_data  = beatData(seed, k);
            l2_rsp_last  = (k == last_index);
            waited = 0;
            while (!l2_rsp_ready && waited < TIMEOUT) begin
                @(posedge CLK); #1;
                waited++;
            end
            if (!l2_rsp_ready) begin
                checkOutput("beat_accept_timeout", 0, 1);
                l2_rsp_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
            l2_rsp_valid = 1'b0;
            l2_rsp_last  = 1'b0;
            repeat (gap) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    // L1 side: wait for the line, optionally stall it (with a new miss
    // pending), accept it, and if a miss was pending see it taken next cycle.
    task automatic receiveLine(input int stall, input logic [LINE_W-1:0] expected,
                               input bit check_latency, input bit new_req,
                               input logic [ADDR_W-1:0] new_addr);
        int waited = 0;
        data_ready = 1'b0;
        while (!data_valid && waited < TIMEOUT) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (!data_valid) begin
            checkOutput("line_valid_timeout", 0, 1);
            return;
        end
        if (check_latency) begin
            checkOutput("line_valid_latency", cycle_count + 1 - accept_cycle, 6);
        end
        checkOutput("line_data", data_out, expected);
        checkOutput("rsp_ready_low_in_resp", l2_rsp_ready, 0);
        if (new_req) begin
            addr_valid = 1'b1;
            addr_in    = new_addr;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge CLK); #1;
            checkOutput("line_stable_while_stalled", data_out, expected);
            checkOutput("line_valid_held", data_valid, 1);
            checkOutput("addr_ready_low_in_resp", addr_ready, 0);
        end
        data_ready = 1'b1;
        @(posedge CLK); #1;
        data_ready = 1'b0;
        checkOutput("line_valid_drops_after_accept", data_valid, 0);
        if (new_req) begin
            checkOutput("pending_request_not_taken_yet", l2_req_valid, 0);
            checkOutput("addr_ready_back_in_idle", addr_ready, 1);
            @(posedge CLK); #1;
            addr_valid   = 1'b0;
            accept_cycle = cycle_count;
            checkOutput("pending_request_accepted", l2_req_valid, 1);
            checkOutput("pending_request_address", l2_req_address, new_addr);
        end
    endtask

    initial begin
        RST          = 1'b1;
        addr_valid   = 1'b0;
        addr_in      = '0;
        data_ready   = 1'b0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = '0;
        l2_rsp_last  = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_addr_ready", addr_ready, 0);
        checkOutput("reset_req_valid", l2_req_valid, 0);
        checkOutput("reset_rsp_ready", l2_rsp_ready, 0);
        checkOutput("reset_data_valid", data_valid, 0);
        checkOutput("reset_req_address", l2_req_address, 0);
        checkOutput("reset_line", data_out, 0);
        checkOutput("reset_protocol_error", protocol_error, 0);
        checkOutput("reset_refill_count", refill_count, 0);
        RST = 1'b0;
        #1;
        checkOutput("addr_ready_after_reset", addr_ready, 1);

        // Test 1: minimum-latency refill
        beats_before = beats_accepted;
        fork
            applyStimulus(26'h0ABCDE);
            serveL2(0, 0, 3, 4, 0, 26'h0ABCDE);
            receiveLine(0, lineData(0), 1'b1, 1'b0, '0);
        join
        checkOutput("t1_refill_count", refill_count, 1);
        checkOutput("t1_beats_consumed", beats_accepted - beats_before, 4);
        checkOutput("t1_no_protocol_error", protocol_error, 0);

        // Test 2: stalled L2 request and gapped beats
        beats_before = beats_accepted;
        fork
            applyStimulus(26'h2A5A5A5);
            serveL2(5, 2, 3, 4, 0, 26'h2A5A5A5);
            receiveLine(0, lineData(0), 1'b0, 1'b0, '0);
        join
        checkOutput("t2_refill_count", refill_count, 2);
        checkOutput("t2_beats_consumed", beats_accepted - beats_before, 4);

        // Test 3: L1 stalls the line while the next miss is already waiting
        fork
            applyStimulus(26'h0000123);
            serveL2(0, 0, 3, 4, 5, 26'h0000123);
            receiveLine(4, lineData(5), 1'b0, 1'b1, 26'h3FFFFFF);
        join
        fork
            serveL2(0, 0, 3, 4, 9, 26'h3FFFFFF);
            receiveLine(0, lineData(9), 1'b1, 1'b0, '0);
        join
        checkOutput("t3_refill_count", refill_count, 4);

        // Test 4: LAST on beat 1 sets the sticky error but the fill completes
        beats_before = beats_accepted;
        fork
            applyStimulus(26'h0155555);
            serveL2(0, 0, 1, 4, 2, 26'h0155555);
            receiveLine(0, lineData(2), 1'b0, 1'b0, '0);
        join
        checkOutput("t4_protocol_error_set", protocol_error, 1);
        checkOutput("t4_beats_consumed", beats_accepted - beats_before, 4);
        fork
            applyStimulus(26'h0066666);
            serveL2(0, 0, 3, 4, 6, 26'h0066666);
            receiveLine(0, lineData(6), 1'b0, 1'b0, '0);
        join
        checkOutput("t4_protocol_error_sticky", protocol_error, 1);
        checkOutput("t4_refill_count", refill_count, 6);

        // Test 5: reset in the middle of a fill
        beats_before = beats_accepted;
        fork
            applyStimulus(26'h0222222);
            serveL2(0, 0, 3, 2, 7, 26'h0222222);
        join
        checkOutput("t5_partial_beats", beats_accepted - beats_before, 2);
        RST = 1'b1;
        @(posedge CLK); #1;
        checkOutput("t5_rst_addr_ready", addr_ready, 0);
        checkOutput("t5_rst_req_valid", l2_req_valid, 0);
        checkOutput("t5_rst_rsp_ready", l2_rsp_ready, 0);
        checkOutput("t5_rst_data_valid", data_valid, 0);
        checkOutput("t5_rst_req_address", l2_req_address, 0);
        checkOutput("t5_rst_line", data_out, 0);
        checkOutput("t5_rst_protocol_error", protocol_error, 0);
        checkOutput("t5_rst_refill_count", refill_count, 0);
        RST = 1'b0;
        #1;
        checkOutput("t5_addr_ready_after_rst", addr_ready, 1);
        fork
            applyStimulus(26'h1357913);
            serveL2(0, 0, 3, 4, 3, 26'h1357913);
            receiveLine(0, lineData(3), 1'b1, 1'b0, '0);
        join
        checkOutput("t5_fresh_refill_count", refill_count, 1);
        checkOutput("t5_fresh_no_error", protocol_error, 0);

        // Test 6: refill counter saturation
        force dut.refill_count_q = 32'hFFFF_FFFE;
        @(posedge CLK); #1;
        release dut.refill_count_q;
        checkOutput("t6_preloaded_count", refill_count, 32'hFFFF_FFFE);
        fork
            applyStimulus(26'h0001000);
            serveL2(0, 0, 3, 4, 1, 26'h0001000);
            receiveLine(0, lineData(1), 1'b0, 1'b0, '0);
        join
        checkOutput("t6_count_reaches_max", refill_count, 32'hFFFF_FFFF);
        fork
            applyStimulus(26'h0002000);
            serveL2(0, 0, 3, 4, 4, 26'h0002000);
            receiveLine(0, lineData(4), 1'b0, 1'b0, '0);
        join
        checkOutput("t6_count_saturates", refill_count, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
